// File: rtl/rr_dispatch_pkg.sv
// Shared state encoding and index-width helper for the round-robin grant dispatcher.
package rr_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      POP   = 2'd2
   } state_e;

   // Width of an index into n items; never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_grant_dispatcher_if.sv
// Queue-head / requester bundle for rr_grant_dispatcher; master is the dispatcher side.
interface rr_grant_dispatcher_if
   import rr_dispatch_pkg::*;
#(
   parameter int unsigned N = 4
);
   localparam int unsigned IW = idx_w(N);

   logic [N-1:0]  req_i;
   logic          is_empty_i;
   logic          pop_o;
   logic [N-1:0]  gnt_o;
   logic [IW-1:0] gnt_idx_o;
   logic [N-1:0]  done_i;
   logic          timeout_o;

   modport master (
      input  req_i, is_empty_i, done_i,
      output pop_o, gnt_o, gnt_idx_o, timeout_o
   );

   modport slave (
      output req_i, is_empty_i, done_i,
      input  pop_o, gnt_o, gnt_idx_o, timeout_o
   );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of mask strictly after last_ptr, wrapping.
module rr_pick
   import rr_dispatch_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] last_ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [IW-1:0] pos;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = int'(N); k >= 1; k--) begin
         pos = IW'((int'(last_ptr) + k) % int'(N));
         if (mask[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_grant_dispatcher.sv
// Grants each requester of the queue head once in round-robin order, then pops the head.
// Optional forced release after HOLD_MAX cycles when GNT_TIMEOUT_EN is defined.
module rr_grant_dispatcher
   import rr_dispatch_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rr_grant_dispatcher_if.master bus
);

   localparam int unsigned IW = idx_w(N);
   localparam int unsigned CW = idx_w(HOLD_MAX);

`ifdef GNT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   // A one-cycle hold limit expires on the very first grant cycle.
   localparam bit TMO_FIRST = TMO_EN && (HOLD_MAX == 1);

   state_e        state_q, state_d;
   logic [N-1:0]  entry_q, entry_d;
   logic [N-1:0]  served_q, served_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pop_q, pop_d;
   logic          tmo_q, tmo_d;

   logic [N-1:0]  served_upd;
   logic [N-1:0]  pick_mask;
   logic [IW-1:0] pick_ptr;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic          expire_c;
   logic          release_c;

   rr_pick #(.N(N)) u_pick (
      .mask     (pick_mask),
      .last_ptr (pick_ptr),
      .idx      (pick_idx),
      .found    (pick_found)
   );

   assign served_upd = served_q | gnt_q;
   assign expire_c   = TMO_EN && (cnt_q == CW'(HOLD_MAX - 1));
   assign release_c  = bus.done_i[idx_q] || expire_c;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         entry_q  <= '0;
         served_q <= '0;
         gnt_q    <= '0;
         idx_q    <= '0;
         last_q   <= IW'(N - 1);
         cnt_q    <= '0;
         pop_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         served_q <= served_d;
         gnt_q    <= gnt_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         pop_q    <= pop_d;
         tmo_q    <= tmo_d;
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      entry_d   = entry_q;
      served_d  = served_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      pop_d     = 1'b0;
      tmo_d     = 1'b0;
      pick_mask = bus.req_i;
      pick_ptr  = last_q;

      unique case (state_q)
         IDLE: begin
            if (!bus.is_empty_i && (|bus.req_i)) begin
               entry_d = bus.req_i;
               idx_d   = pick_idx;
               gnt_d   = N'(1) << pick_idx;
               cnt_d   = '0;
               tmo_d   = TMO_FIRST;
               state_d = GRANT;
            end
         end

         GRANT: begin
            pick_mask = entry_q & ~served_upd;
            pick_ptr  = idx_q;
            if (bus.is_empty_i) begin
               // Queue cleared underneath us: drop the entry without popping.
               gnt_d    = '0;
               served_d = '0;
               cnt_d    = '0;
               state_d  = IDLE;
            end else if (release_c) begin
               served_d = served_upd;
               last_d   = idx_q;
               cnt_d    = '0;
               if (pick_found) begin
                  idx_d = pick_idx;
                  gnt_d = N'(1) << pick_idx;
                  tmo_d = TMO_FIRST;
               end else begin
                  gnt_d   = '0;
                  pop_d   = 1'b1;
                  state_d = POP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               tmo_d = TMO_EN && (cnt_d == CW'(HOLD_MAX - 1));
            end
         end

         POP: begin
            served_d = '0;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   assign bus.gnt_o     = gnt_q;
   assign bus.gnt_idx_o = idx_q;
   assign bus.pop_o     = pop_q;
   assign bus.timeout_o = tmo_q;

endmodule

// File: tb/tb_rr_grant_dispatcher.sv
// Directed bench for rr_grant_dispatcher; expected values are hand-derived per step.
module tb_rr_grant_dispatcher;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   rr_grant_dispatcher_if #(.N(4)) bus ();

   rr_grant_dispatcher #(.N(4), .HOLD_MAX(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] gnt, input logic pop,
                             input logic tmo);
      check({tag, ".gnt"}, 32'(bus.gnt_o), 32'(gnt));
      check({tag, ".pop"}, 32'(bus.pop_o), 32'(pop));
      check({tag, ".tmo"}, 32'(bus.timeout_o), 32'(tmo));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      bus.req_i      = 4'b1111;
      bus.is_empty_i = 1'b0;
      bus.done_i     = 4'b0000;

      // Reset held two cycles with a full head present
      step(); expect_out("rst0", 4'b0000, 1'b0, 1'b0);
      check("rst0.idx", 32'(bus.gnt_idx_o), 32'd0);
      step(); expect_out("rst1", 4'b0000, 1'b0, 1'b0);

      // Basic: head 1010 -> grant 1, then 3, then pop
      rst_n = 1'b1; bus.req_i = 4'b1010;
      step(); expect_out("basic_g1", 4'b0010, 1'b0, 1'b0);
      check("basic_g1.idx", 32'(bus.gnt_idx_o), 32'd1);
      bus.done_i = 4'b0010;
      step(); expect_out("basic_g3", 4'b1000, 1'b0, 1'b0);
      check("basic_g3.idx", 32'(bus.gnt_idx_o), 32'd3);
      bus.done_i = 4'b1000;
      step(); expect_out("basic_pop", 4'b0000, 1'b1, 1'b0);
      bus.done_i = 4'b0000; bus.is_empty_i = 1'b1; bus.req_i = 4'b0000;
      step(); expect_out("basic_idle", 4'b0000, 1'b0, 1'b0);

      // Fairness: serve 0010 so last_ptr=1, then 1111 grants 2,3,0,1
      bus.is_empty_i = 1'b0; bus.req_i = 4'b0010;
      step(); expect_out("fair_pre", 4'b0010, 1'b0, 1'b0);
      bus.done_i = 4'b0010;
      step(); expect_out("fair_pre_pop", 4'b0000, 1'b1, 1'b0);
      bus.done_i = 4'b0000; bus.req_i = 4'b1111;
      step(); expect_out("fair_idle", 4'b0000, 1'b0, 1'b0);
      step(); expect_out("fair_g2", 4'b0100, 1'b0, 1'b0);
      check("fair_g2.idx", 32'(bus.gnt_idx_o), 32'd2);
      bus.done_i = 4'b0001;
      step(); expect_out("stray_done", 4'b0100, 1'b0, 1'b0);
      check("stray_done.idx", 32'(bus.gnt_idx_o), 32'd2);
      bus.done_i = 4'b0100;
      step(); expect_out("fair_g3", 4'b1000, 1'b0, 1'b0);
      bus.done_i = 4'b1000;
      step(); expect_out("fair_g0", 4'b0001, 1'b0, 1'b0);
      bus.done_i = 4'b0001;
      step(); expect_out("fair_g1", 4'b0010, 1'b0, 1'b0);
      bus.done_i = 4'b0010;
      step(); expect_out("fair_pop", 4'b0000, 1'b1, 1'b0);
      bus.done_i = 4'b0000; bus.is_empty_i = 1'b1; bus.req_i = 4'b0000;
      step(); expect_out("fair_once", 4'b0000, 1'b0, 1'b0);

      // Abort: empty together with done on grantee 0 of 0011
      bus.is_empty_i = 1'b0; bus.req_i = 4'b0011;
      step(); expect_out("abort_g0", 4'b0001, 1'b0, 1'b0);
      bus.is_empty_i = 1'b1; bus.done_i = 4'b0001;
      step(); expect_out("abort", 4'b0000, 1'b0, 1'b0);
      bus.done_i = 4'b0000;
      step(); expect_out("abort_idle", 4'b0000, 1'b0, 1'b0);
      // served cleared and last_ptr still 1, so index 0 is granted again
      bus.is_empty_i = 1'b0;
      step(); expect_out("abort_regrant", 4'b0001, 1'b0, 1'b0);
      bus.done_i = 4'b0001;
      step(); expect_out("abort_g1", 4'b0010, 1'b0, 1'b0);
      bus.done_i = 4'b0010;
      step(); expect_out("abort_pop", 4'b0000, 1'b1, 1'b0);
      bus.done_i = 4'b0000; bus.is_empty_i = 1'b1; bus.req_i = 4'b0000;
      step(); expect_out("abort_end", 4'b0000, 1'b0, 1'b0);

      // Reset in the middle of a grant
      bus.is_empty_i = 1'b0; bus.req_i = 4'b0100;
      step(); expect_out("mid_g2", 4'b0100, 1'b0, 1'b0);
      rst_n = 1'b0;
      step(); expect_out("mid_rst", 4'b0000, 1'b0, 1'b0);
      check("mid_rst.idx", 32'(bus.gnt_idx_o), 32'd0);
      rst_n = 1'b1;
      step(); expect_out("hold_c1", 4'b0100, 1'b0, 1'b0);

`ifdef GNT_TIMEOUT_EN
      // No done: grant held 8 cycles, timeout on the 8th, then pop
      for (int i = 2; i <= 8; i++) begin
         step(); expect_out($sformatf("hold_c%0d", i), 4'b0100, 1'b0, (i == 8));
      end
      step(); expect_out("tmo_pop", 4'b0000, 1'b1, 1'b0);
`else
      // No done: grant held indefinitely with no timeout
      for (int i = 2; i <= 12; i++) begin
         step(); expect_out($sformatf("hold_c%0d", i), 4'b0100, 1'b0, 1'b0);
      end
      bus.done_i = 4'b0100;
      step(); expect_out("hold_pop", 4'b0000, 1'b1, 1'b0);
`endif
      bus.done_i = 4'b0000; bus.is_empty_i = 1'b1; bus.req_i = 4'b0000;
      step(); expect_out("final_idle", 4'b0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
